channel_cu: RTL and testbench

Emulated single-device control unit on parallel channel "A": the peer that the channel master selects, sends commands to, and exchanges data and status with over the tag/bus interface. It answers selection at one device address and accepts commands. It presents initial and ending status and moves data through an internal byte buffer. Used as the channel's loop-back partner in simulation and on the FPGA.

---
 rtl/channel_cu.sv | 226 ++++++++++++++++++++++
 tb/tb_channel_cu.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_cu.sv
// channel_cu: emulated single-device control unit on parallel channel A (select, command, status, byte buffer).
// Optional bus-out parity checking is compiled in with CHANNEL_CU_PARITY_CHECK_EN.
module channel_cu #(
  parameter logic [7:0] ADDR  = 8'h50,
  parameter int         DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              a_bus_out,
  input  logic                    a_bus_out_parity,
  input  logic                    a_operational_out,
  input  logic                    a_hold_out,
  input  logic                    a_select_out,
  input  logic                    a_address_out,
  input  logic                    a_command_out,
  input  logic                    a_service_out,
  input  logic                    a_suppress_out,
  output logic [7:0]              a_bus_in,
  output logic                    a_bus_in_parity,
  output logic                    a_operational_in,
  output logic                    a_select_in,
  output logic                    a_address_in,
  output logic                    a_status_in,
  output logic                    a_service_in,
  output logic                    a_request_in,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  buf_len
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  localparam logic [2:0] CMD_TIO   = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [2:0] CMD_NOOP  = 3'd3;

  localparam logic [7:0] ST_OK   = 8'h00;
  localparam logic [7:0] ST_END  = 8'h30;
  localparam logic [7:0] ST_REJ  = 8'h40;
  localparam logic [7:0] ST_DERR = 8'h70;

  typedef enum logic [3:0] {
    IDLE, PASS, ADDR_IN, CMD_DROP, INIT_ST, INIT_WAIT,
    DATA, DATA_WAIT, STOP_WAIT, END_ST, END_WAIT
  } state_t;

  state_t         state_q;
  logic [7:0]     bus_in_q;
  logic           op_in_q, sel_in_q, addr_in_q, stat_in_q, svc_in_q;
  logic [2:0]     cmd_q;
  logic           rej_q, derr_q;
  logic           sense_rej_q, sense_bchk_q;
  logic [LW-1:0]  count_q, idx_q, len_q;
  logic [7:0]     buf_q [DEPTH];

  logic           par_err;
  logic           cmd_ok;
  logic           xfer_end;
  logic [7:0]     sense_byte;
  logic           unused_inputs;

`ifdef CHANNEL_CU_PARITY_CHECK_EN
  assign par_err = ~^{a_bus_out, a_bus_out_parity};
`else
  assign par_err = 1'b0;
`endif

  assign unused_inputs = ^{a_hold_out, a_suppress_out, a_bus_out_parity};
  assign cmd_ok        = (a_bus_out <= 8'h04);
  assign sense_byte    = {5'b0, sense_bchk_q, 1'b0, sense_rej_q};
  // sense always moves exactly one byte
  assign xfer_end      = derr_q
                      || ((cmd_q == CMD_WRITE) && (count_q == FULL))
                      || ((cmd_q == CMD_READ) && (idx_q == len_q))
                      || ((cmd_q != CMD_WRITE) && (cmd_q != CMD_READ));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bus_in_q     <= '0;
      op_in_q      <= 1'b0;
      sel_in_q     <= 1'b0;
      addr_in_q    <= 1'b0;
      stat_in_q    <= 1'b0;
      svc_in_q     <= 1'b0;
      cmd_q        <= '0;
      rej_q        <= 1'b0;
      derr_q       <= 1'b0;
      sense_rej_q  <= 1'b0;
      sense_bchk_q <= 1'b0;
      count_q      <= '0;
      idx_q        <= '0;
      len_q        <= '0;
    end else if (!a_operational_out) begin
      state_q      <= IDLE;
      bus_in_q     <= '0;
      op_in_q      <= 1'b0;
      sel_in_q     <= 1'b0;
      addr_in_q    <= 1'b0;
      stat_in_q    <= 1'b0;
      svc_in_q     <= 1'b0;
      sense_rej_q  <= 1'b0;
      sense_bchk_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (a_select_out && a_address_out) begin
          if (a_bus_out == ADDR) begin
            op_in_q   <= 1'b1;
            addr_in_q <= 1'b1;
            bus_in_q  <= ADDR;
            state_q   <= ADDR_IN;
          end else begin
            sel_in_q  <= 1'b1;
            state_q   <= PASS;
          end
        end
        PASS: if (!a_select_out) begin
          sel_in_q <= 1'b0;
          state_q  <= IDLE;
        end
        ADDR_IN: if (a_command_out) begin
          cmd_q     <= a_bus_out[2:0];
          rej_q     <= !cmd_ok || par_err;
          derr_q    <= 1'b0;
          if (!cmd_ok) sense_rej_q  <= 1'b1;
          if (par_err) sense_bchk_q <= 1'b1;
          addr_in_q <= 1'b0;
          bus_in_q  <= '0;
          state_q   <= CMD_DROP;
        end
        CMD_DROP: if (!a_command_out) begin
          stat_in_q <= 1'b1;
          bus_in_q  <= rej_q ? ST_REJ : ST_OK;
          state_q   <= INIT_ST;
        end
        INIT_ST: if (a_service_out) begin
          stat_in_q <= 1'b0;
          bus_in_q  <= '0;
          state_q   <= INIT_WAIT;
        end
        INIT_WAIT: if (!a_service_out) begin
          if (rej_q || (cmd_q == CMD_TIO)) begin
            op_in_q <= 1'b0;
            state_q <= IDLE;
          end else if (cmd_q == CMD_NOOP || (cmd_q == CMD_READ && len_q == '0)) begin
            stat_in_q <= 1'b1;
            bus_in_q  <= ST_END;
            state_q   <= END_ST;
          end else begin
            count_q  <= '0;
            idx_q    <= '0;
            svc_in_q <= 1'b1;
            if (cmd_q == CMD_READ)       bus_in_q <= buf_q[0];
            else if (cmd_q == CMD_WRITE) bus_in_q <= '0;
            else                         bus_in_q <= sense_byte;
            state_q  <= DATA;
          end
        end
        DATA: if (a_command_out) begin
          svc_in_q <= 1'b0;
          bus_in_q <= '0;
          state_q  <= STOP_WAIT;
        end else if (a_service_out) begin
          svc_in_q <= 1'b0;
          bus_in_q <= '0;
          state_q  <= DATA_WAIT;
          if (cmd_q == CMD_WRITE) begin
            if (par_err) begin
              derr_q       <= 1'b1;
              sense_bchk_q <= 1'b1;
            end else begin
              buf_q[count_q[AW-1:0]] <= a_bus_out;
              count_q                <= count_q + LW'(1);
            end
          end else if (cmd_q == CMD_READ) begin
            idx_q <= idx_q + LW'(1);
          end else begin
            sense_rej_q  <= 1'b0;
            sense_bchk_q <= 1'b0;
          end
        end
        DATA_WAIT: if (!a_service_out) begin
          if (xfer_end) begin
            stat_in_q <= 1'b1;
            bus_in_q  <= derr_q ? ST_DERR : ST_END;
            state_q   <= END_ST;
          end else begin
            svc_in_q <= 1'b1;
            bus_in_q <= (cmd_q == CMD_READ) ? buf_q[idx_q[AW-1:0]] : 8'h00;
            state_q  <= DATA;
          end
        end
        STOP_WAIT: if (!a_command_out) begin
          stat_in_q <= 1'b1;
          bus_in_q  <= ST_END;
          state_q   <= END_ST;
        end
        END_ST: if (a_service_out) begin
          stat_in_q <= 1'b0;
          bus_in_q  <= '0;
          state_q   <= END_WAIT;
        end
        END_WAIT: if (!a_service_out) begin
          op_in_q <= 1'b0;
          if (cmd_q == CMD_WRITE) len_q <= count_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_bus_in         = bus_in_q;
  assign a_bus_in_parity  = ~^bus_in_q;
  assign a_operational_in = op_in_q;
  assign a_select_in      = sel_in_q;
  assign a_address_in     = addr_in_q;
  assign a_status_in      = stat_in_q;
  assign a_service_in     = svc_in_q;
  assign a_request_in     = 1'b0;
  assign busy             = (state_q != IDLE);
  assign buf_len          = len_q;

endmodule

// File: tb/tb_channel_cu.sv
// tb_channel_cu: channel-master sequences against channel_cu, checked with a buffer/sense model.
`timescale 1ns/1ps
module tb_channel_cu;
  localparam logic [7:0] ADDR  = 8'h50;
  localparam int         DEPTH = 16;
`ifdef CHANNEL_CU_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [7:0] a_bus_out;
  logic a_bus_out_parity, a_operational_out, a_hold_out, a_select_out;
  logic a_address_out, a_command_out, a_service_out, a_suppress_out;
  logic [7:0] a_bus_in;
  logic a_bus_in_parity, a_operational_in, a_select_in, a_address_in;
  logic a_status_in, a_service_in, a_request_in, busy;
  logic [$clog2(DEPTH):0] buf_len;

  always #5 clk = ~clk;

  channel_cu #(.ADDR(ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_bus_out(a_bus_out), .a_bus_out_parity(a_bus_out_parity),
    .a_operational_out(a_operational_out), .a_hold_out(a_hold_out),
    .a_select_out(a_select_out), .a_address_out(a_address_out),
    .a_command_out(a_command_out), .a_service_out(a_service_out),
    .a_suppress_out(a_suppress_out),
    .a_bus_in(a_bus_in), .a_bus_in_parity(a_bus_in_parity),
    .a_operational_in(a_operational_in), .a_select_in(a_select_in),
    .a_address_in(a_address_in), .a_status_in(a_status_in),
    .a_service_in(a_service_in), .a_request_in(a_request_in),
    .busy(busy), .buf_len(buf_len)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] wdata [32];
  logic [8:0] rdata [32];
  // model: buffer image, valid length, sense bits
  logic [7:0] m_mem [DEPTH];
  int m_len = 0;
  bit m_rej = 1'b0;
  bit m_bchk = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tag_val(input int w);
    case (w)
      0:       return a_operational_in;
      1:       return a_select_in;
      2:       return a_address_in;
      3:       return a_status_in;
      default: return a_service_in;
    endcase
  endfunction

  task automatic wait_tag(input int w, input logic v, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tag_val(w) === v) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk({"wait ", tag}, 32'(found), 32'd1);
  endtask

  task automatic put_bus(input logic [7:0] v, input bit bad);
    a_bus_out        = v;
    a_bus_out_parity = bad ? ^v : ~^v;
  endtask

  task automatic run_cmd(input logic [7:0] cmd, input int offer_n, input int bad_idx,
                         input bit stop_both, input int abort_at,
                         output logic [8:0] init_st, output logic [9:0] end_st, output int n_xfer);
    bit done = 1'b0;
    end_st = '0;
    n_xfer = 0;
    put_bus(ADDR, 1'b0);
    a_hold_out = 1'b1; a_select_out = 1'b1; a_address_out = 1'b1;
    wait_tag(2, 1'b1, "address_in");
    chk("address bus_in", 32'(a_bus_in), 32'(ADDR));
    a_address_out = 1'b0;
    put_bus(cmd, bad_idx == -2);
    a_command_out = 1'b1;
    wait_tag(2, 1'b0, "address_in drop");
    a_command_out = 1'b0;
    put_bus(8'h00, 1'b0);
    wait_tag(3, 1'b1, "initial status_in");
    init_st = {a_bus_in_parity, a_bus_in};
    a_service_out = 1'b1;
    wait_tag(3, 1'b0, "initial status drop");
    a_service_out = 1'b0;
    for (int g = 0; g < 100 && !done; g++) begin
      step();
      if (!a_operational_in) begin
        done = 1'b1;
      end else if (a_status_in) begin
        end_st = {1'b1, a_bus_in_parity, a_bus_in};
        a_service_out = 1'b1;
        wait_tag(3, 1'b0, "ending status drop");
        a_service_out = 1'b0;
        wait_tag(0, 1'b0, "operational_in drop");
        done = 1'b1;
      end else if (a_service_in) begin
        if (abort_at == n_xfer) begin
          a_operational_out = 1'b0;
          step();
          chk("abort tags", 32'({a_operational_in, a_select_in, a_address_in,
                                 a_status_in, a_service_in, busy}), 32'd0);
          chk("abort bus_in", 32'(a_bus_in), 32'd0);
          a_operational_out = 1'b1;
          done = 1'b1;
        end else if (cmd == 8'h01) begin
          if (n_xfer < offer_n) begin
            put_bus(wdata[n_xfer], n_xfer == bad_idx);
            a_service_out = 1'b1;
            wait_tag(4, 1'b0, "write service_in drop");
            a_service_out = 1'b0;
            n_xfer++;
          end else begin
            a_command_out = 1'b1;
            if (stop_both) begin
              put_bus(8'hEE, 1'b0);
              a_service_out = 1'b1;
            end
            wait_tag(4, 1'b0, "stop service_in drop");
            a_command_out = 1'b0;
            a_service_out = 1'b0;
          end
        end else begin
          if (n_xfer < 32) rdata[n_xfer] = {a_bus_in_parity, a_bus_in};
          a_service_out = 1'b1;
          wait_tag(4, 1'b0, "read service_in drop");
          a_service_out = 1'b0;
          n_xfer++;
        end
      end
    end
    chk("sequence completes", 32'(done), 32'd1);
    a_select_out = 1'b0; a_hold_out = 1'b0;
    put_bus(8'h00, 1'b0);
    step();
  endtask

  task automatic do_and_check(input string name, input logic [7:0] cmd, input int offer_n,
                              input int bad_idx, input bit stop_both, input int abort_at);
    logic [8:0] init_st;
    logic [9:0] end_st;
    int n;
    logic [7:0] exp_init;
    logic [7:0] exp_end = 8'h30;
    logic [7:0] exp_bytes [32];
    bit exp_seen = 1'b0;
    int exp_n = 0;
    bit cmd_perr = PAR_EN && (bad_idx == -2);
    bit invalid = (cmd > 8'h04);
    bit rej = invalid || cmd_perr;
    exp_init = rej ? 8'h40 : 8'h00;
    if (invalid)  m_rej  = 1'b1;
    if (cmd_perr) m_bchk = 1'b1;
    if (!rej && abort_at == 0) begin
      m_rej = 1'b0;
      m_bchk = 1'b0;
    end else if (!rej) begin
      case (cmd)
        8'h01: begin
          int acc = (offer_n < DEPTH) ? offer_n : DEPTH;
          exp_seen = 1'b1;
          if (PAR_EN && bad_idx >= 0 && bad_idx < acc) begin
            acc = bad_idx;
            exp_n = bad_idx + 1;
            exp_end = 8'h70;
            m_bchk = 1'b1;
          end else begin
            exp_n = acc;
          end
          for (int k = 0; k < acc; k++) m_mem[k] = wdata[k];
          m_len = acc;
        end
        8'h02: begin
          exp_seen = 1'b1;
          exp_n = m_len;
          for (int k = 0; k < m_len; k++) exp_bytes[k] = m_mem[k];
        end
        8'h03: exp_seen = 1'b1;
        8'h04: begin
          exp_seen = 1'b1;
          exp_n = 1;
          exp_bytes[0] = {5'b0, m_bchk, 1'b0, m_rej};
          m_rej = 1'b0;
          m_bchk = 1'b0;
        end
        default: ;
      endcase
    end
    run_cmd(cmd, offer_n, bad_idx, stop_both, abort_at, init_st, end_st, n);
    chk({name, " initial status"}, 32'(init_st), 32'({~^exp_init, exp_init}));
    chk({name, " ending presented"}, 32'(end_st[9]), 32'(exp_seen));
    if (exp_seen) chk({name, " ending status"}, 32'(end_st[8:0]), 32'({~^exp_end, exp_end}));
    chk({name, " byte count"}, 32'(n), 32'(exp_n));
    if (cmd == 8'h02 || cmd == 8'h04)
      for (int k = 0; k < exp_n && k < 32; k++)
        chk($sformatf("%s byte %0d", name, k), 32'(rdata[k]), 32'({~^exp_bytes[k], exp_bytes[k]}));
    chk({name, " buf_len"}, 32'(buf_len), 32'(m_len));
    chk({name, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] other;
    reset = 1'b1;
    put_bus(8'h00, 1'b0);
    a_operational_out = 1'b1; a_hold_out = 1'b0; a_select_out = 1'b0;
    a_address_out = 1'b0; a_command_out = 1'b0; a_service_out = 1'b0;
    a_suppress_out = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("reset tags", 32'({a_operational_in, a_select_in, a_address_in, a_status_in,
                           a_service_in, a_request_in, busy}), 32'd0);
    chk("reset bus_in", 32'(a_bus_in), 32'd0);
    chk("reset buf_len", 32'(buf_len), 32'd0);
    reset = 1'b0;
    step();

    do_and_check("test io", 8'h00, 0, -1, 1'b0, -1);

    other = 8'(ADDR + 8'($urandom_range(1, 255)));
    put_bus(other, 1'b0);
    a_select_out = 1'b1; a_address_out = 1'b1;
    step();
    chk("pass select_in", 32'(a_select_in), 32'd1);
    chk("pass operational_in", 32'(a_operational_in), 32'd0);
    step(); step();
    chk("pass select_in held", 32'(a_select_in), 32'd1);
    a_select_out = 1'b0; a_address_out = 1'b0;
    step();
    chk("pass select_in drop", 32'(a_select_in), 32'd0);
    chk("pass busy", 32'(busy), 32'd0);

    wdata[0] = 8'hA1; wdata[1] = 8'hB2; wdata[2] = 8'hC3;
    do_and_check("write3", 8'h01, 3, -1, 1'b0, -1);
    do_and_check("read3", 8'h02, 0, -1, 1'b0, -1);

    do_and_check("write0", 8'h01, 0, -1, 1'b0, -1);
    do_and_check("read0", 8'h02, 0, -1, 1'b0, -1);

    for (int k = 0; k <= DEPTH; k++) wdata[k] = 8'($urandom);
    do_and_check("write full", 8'h01, DEPTH + 1, -1, 1'b0, -1);
    do_and_check("read full", 8'h02, 0, -1, 1'b0, -1);

    do_and_check("cmd 07", 8'h07, 0, -1, 1'b0, -1);
    do_and_check("sense1", 8'h04, 0, -1, 1'b0, -1);
    do_and_check("sense2", 8'h04, 0, -1, 1'b0, -1);
    do_and_check("random reject", 8'($urandom_range(5, 255)), 0, -1, 1'b0, -1);
    do_and_check("noop", 8'h03, 0, -1, 1'b0, -1);
    do_and_check("sense3", 8'h04, 0, -1, 1'b0, -1);

    for (int k = 0; k < 2; k++) wdata[k] = 8'($urandom);
    do_and_check("stop with service", 8'h01, 2, -1, 1'b1, -1);
    do_and_check("read stop", 8'h02, 0, -1, 1'b0, -1);

    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) wdata[k] = 8'($urandom);
      do_and_check($sformatf("rand write %0d", r), 8'h01, n, -1, 1'b0, -1);
      do_and_check($sformatf("rand read %0d", r), 8'h02, 0, -1, 1'b0, -1);
    end

    do_and_check("cmd 09", 8'h09, 0, -1, 1'b0, -1);
    do_and_check("abort write", 8'h01, 4, -1, 1'b0, 0);
    do_and_check("read after abort", 8'h02, 0, -1, 1'b0, -1);
    do_and_check("sense after abort", 8'h04, 0, -1, 1'b0, -1);

    if (PAR_EN) begin
      for (int k = 0; k < 3; k++) wdata[k] = 8'($urandom);
      do_and_check("bad data parity", 8'h01, 3, 1, 1'b0, -1);
      do_and_check("sense bchk", 8'h04, 0, -1, 1'b0, -1);
      do_and_check("bad cmd parity", 8'h02, 0, -2, 1'b0, -1);
      do_and_check("sense cmd bchk", 8'h04, 0, -1, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
